// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with post-reset clear sequencer and write-to-read bypass.
// Optional per-entry even parity with sticky error flag when RF_PARITY_EN is defined.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [NUM_READ*AW-1:0]    raddr,
    output logic [NUM_READ*WIDTH-1:0] rdata,
    output logic                      ready,
    output logic                      parity_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             clr_ptr_q, clr_ptr_d;
    logic                      ready_q, ready_d;
    logic [NUM_READ*WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0]          rf_q [DEPTH];

    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [WIDTH-1:0]          mem_wdata;
    logic [AW-1:0]             ra;

`ifdef RF_PARITY_EN
    logic                      rf_par_q [DEPTH];
    logic                      parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        rdata_d   = '0;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        ra        = '0;
`ifdef RF_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (state_q == ST_CLEAR) begin
            // Entry 0 is never stored; reads of address 0 are forced to zero instead.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
                ready_d = 1'b1;
            end
        end else begin
            mem_we = we && (waddr != '0);
            for (int i = 0; i < NUM_READ; i++) begin
                ra = raddr[i*AW +: AW];
                if (ra == '0) begin
                    rdata_d[i*WIDTH +: WIDTH] = '0;
                end else if (mem_we && (waddr == ra)) begin
                    rdata_d[i*WIDTH +: WIDTH] = wdata;
                end else begin
                    rdata_d[i*WIDTH +: WIDTH] = rf_q[ra];
`ifdef RF_PARITY_EN
                    if ((^rf_q[ra]) != rf_par_q[ra]) begin
                        parity_err_d = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= AW'(1);
            ready_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef RF_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
`ifdef RF_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
            if (mem_we) begin
                rf_q[mem_waddr] <= mem_wdata;
`ifdef RF_PARITY_EN
                rf_par_q[mem_waddr] <= ^mem_wdata;
`endif
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
`ifdef RF_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        we_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic        ready_a;
    logic        perr_a;

    logic        we_b;
    logic [3:0]  waddr_b;
    logic [15:0] wdata_b;
    logic [15:0] raddr_b;
    logic [63:0] rdata_b;
    logic        ready_b;
    logic        perr_b;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2)) dut (
        .clk(clk), .rst_n(rst_n), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .raddr(raddr_a), .rdata(rdata_a), .ready(ready_a), .parity_err(perr_a)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(16), .NUM_READ(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .raddr(raddr_b), .rdata(rdata_b), .ready(ready_b), .parity_err(perr_b)
    );

    // Reference state: contents, edges since reset release, and entries known to hold corrupt data.
    logic [31:0] ma_rf [32];
    bit          ma_bad [32];
    int          ma_cnt;
    bit          ma_ready;
    bit          ma_perr;
    logic [63:0] ea_rdata;

    logic [15:0] mb_rf [16];
    int          mb_cnt;
    bit          mb_ready;
    logic [63:0] eb_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int a;
        if (!rst_n) begin
            ma_cnt = 0; ma_ready = 0; ma_perr = 0; ea_rdata = '0;
        end else if (!ma_ready) begin
            ma_cnt++;
            ea_rdata = '0;
            if (ma_cnt == 31) begin
                ma_ready = 1;
                for (int i = 0; i < 32; i++) begin ma_rf[i] = '0; ma_bad[i] = 0; end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = int'(raddr_a[p*5 +: 5]);
                if (a == 0) ea_rdata[p*32 +: 32] = '0;
                else if (we_a && waddr_a != 0 && int'(waddr_a) == a) ea_rdata[p*32 +: 32] = wdata_a;
                else begin
                    ea_rdata[p*32 +: 32] = ma_rf[a];
                    if (ma_bad[a]) ma_perr = 1;
                end
            end
            if (we_a && waddr_a != 0) begin ma_rf[waddr_a] = wdata_a; ma_bad[waddr_a] = 0; end
        end

        if (!rst_n) begin
            mb_cnt = 0; mb_ready = 0; eb_rdata = '0;
        end else if (!mb_ready) begin
            mb_cnt++;
            eb_rdata = '0;
            if (mb_cnt == 15) begin
                mb_ready = 1;
                for (int i = 0; i < 16; i++) mb_rf[i] = '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                a = int'(raddr_b[p*4 +: 4]);
                if (a == 0) eb_rdata[p*16 +: 16] = '0;
                else if (we_b && waddr_b != 0 && int'(waddr_b) == a) eb_rdata[p*16 +: 16] = wdata_b;
                else eb_rdata[p*16 +: 16] = mb_rf[a];
            end
            if (we_b && waddr_b != 0) mb_rf[waddr_b] = wdata_b;
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "_ready_a"}, {63'd0, ready_a}, {63'd0, ma_ready});
        check({tag, "_rdata_a"}, rdata_a, ea_rdata);
        check({tag, "_perr_a"}, {63'd0, perr_a}, {63'd0, ma_perr});
        check({tag, "_ready_b"}, {63'd0, ready_b}, {63'd0, mb_ready});
        check({tag, "_rdata_b"}, rdata_b, eb_rdata);
        check({tag, "_perr_b"}, {63'd0, perr_b}, 64'd0);
    endtask

    task automatic drive_a(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] r0, input logic [4:0] r1);
        we_a = w; waddr_a = wa; wdata_a = wd; raddr_a = {r1, r0};
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        we_b = 0; waddr_b = 0; wdata_b = 0; raddr_b = 0;
        for (int i = 0; i < 32; i++) begin ma_rf[i] = '0; ma_bad[i] = 0; end
        for (int i = 0; i < 16; i++) mb_rf[i] = '0;
        ma_cnt = 0; ma_ready = 0; ma_perr = 0; ea_rdata = '0;
        mb_cnt = 0; mb_ready = 0; eb_rdata = '0;

        // Clear sequence; writes during CLEAR must be dropped.
        cycle("t1_rst");
        cycle("t1_rst");
        rst_n = 1'b1;
        drive_a(1, 5, 32'hDEADBEEF, 5, 5);
        for (int k = 1; k <= 31; k++) cycle("t1_clr");
        check("t1_ready_after_31", {63'd0, ready_a}, 64'd1);
        drive_a(0, 0, 0, 5, 0);
        cycle("t1_rd5");
        check("t1_r5_zero", {32'd0, rdata_a[31:0]}, 64'd0);

        drive_a(1, 7, 32'h12345678, 0, 0);
        cycle("t2_wr7");
        drive_a(0, 0, 0, 7, 0);
        cycle("t2_rd7");
        check("t2_r7", {32'd0, rdata_a[31:0]}, 64'h12345678);
        drive_a(1, 0, 32'hFFFFFFFF, 0, 0);
        cycle("t2_wr0");
        drive_a(0, 0, 0, 0, 0);
        cycle("t2_rd0");
        check("t2_r0", {32'd0, rdata_a[63:32]}, 64'd0);

        drive_a(1, 3, 32'h11111111, 0, 0);
        cycle("t3_wr3");
        drive_a(1, 3, 32'h22222222, 3, 3);
        cycle("t3_byp");
        check("t3_bypass_both", rdata_a, 64'h22222222_22222222);
        drive_a(1, 4, 32'h33333333, 3, 0);
        cycle("t3_nobyp");
        check("t3_r3_new", {32'd0, rdata_a[31:0]}, 64'h22222222);

        // Reset while the clear pointer sits at entry 10.
        drive_a(1, 20, 32'hCAFEF00D, 0, 0);
        cycle("t4_wr20");
        drive_a(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cycle("t4_rst");
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) cycle("t4_clr");
        rst_n = 1'b0;
        cycle("t4_rst2");
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) cycle("t4_clr2");
        check("t4_not_ready_30", {63'd0, ready_a}, 64'd0);
        cycle("t4_clr2");
        check("t4_ready_31", {63'd0, ready_a}, 64'd1);
        drive_a(0, 0, 0, 20, 0);
        cycle("t4_rd20");
        check("t4_r20_zero", {32'd0, rdata_a[31:0]}, 64'd0);

        // Four-port instance: fill r1..r15 then read r1, r2, r15, r0.
        drive_a(0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            we_b = 1; waddr_b = 4'(i); wdata_b = 16'h0A00 + 16'(i);
            cycle("t5_wr");
        end
        we_b = 0; raddr_b = {4'd0, 4'd15, 4'd2, 4'd1};
        cycle("t5_rd");
        check("t5_four_ports", rdata_b, 64'h0000_0A0F_0A02_0A01);

        // Parity: corrupt r9 behind the design's back when parity is built in.
        drive_a(1, 9, 32'h000000FF, 0, 0);
        cycle("t6_wr9");
`ifdef RF_PARITY_EN
        dut.rf_q[9][0] = ~dut.rf_q[9][0];
        ma_rf[9] = ma_rf[9] ^ 32'h1;
        ma_bad[9] = 1;
        drive_a(0, 0, 0, 9, 0);
        cycle("t6_rd9");
        check("t6_r9_corrupt", {32'd0, rdata_a[31:0]}, 64'h000000FE);
        check("t6_perr_set", {63'd0, perr_a}, 64'd1);
        drive_a(0, 0, 0, 1, 2);
        for (int k = 0; k < 3; k++) cycle("t6_hold");
        check("t6_perr_held", {63'd0, perr_a}, 64'd1);
`else
        drive_a(0, 0, 0, 9, 0);
        cycle("t6_rd9");
        check("t6_r9", {32'd0, rdata_a[31:0]}, 64'h000000FF);
        check("t6_perr_zero", {63'd0, perr_a}, 64'd0);
`endif

        // Randomized traffic with occasional resets; addresses biased toward collisions.
        for (int k = 0; k < 600; k++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            we_a    = $urandom_range(0, 2) != 0;
            waddr_a = 5'($urandom_range(0, 7));
            wdata_a = $urandom;
            raddr_a = {($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 7))};
            we_b    = $urandom_range(0, 1) != 0;
            waddr_b = 4'($urandom_range(0, 15));
            wdata_b = 16'($urandom);
            for (int p = 0; p < 4; p++)
                raddr_b[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? waddr_b : 4'($urandom_range(0, 15));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-pair register memory in the CPU datapath.
- Adds:
  - configurable width, depth and read-port count
  - hardwired-zero entry 0
  - registered reads with write-to-read bypass
  - post-reset hardware clear sequencer
- Sits between decode (read addresses) and write-back (write port).

Parameters:
- WIDTH, 32, data width of each entry in bits.
- DEPTH, 32, number of entries; power of two, >= 4.
- NUM_READ, 2, number of independent read ports, 1..4.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NUM_READ*AW  packed read addresses; port i at [i*AW +: AW].
- rdata  out  NUM_READ*WIDTH  packed registered read data; port i at [i*WIDTH +: WIDTH].
- ready  out  1  high once clear sequence is complete; writes accepted only when high.
- parity_err  out  1  sticky parity error flag; constant 0 unless RF_PARITY_EN is defined.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: any rising edge with rst_n=0 sets:
  - state=CLEAR, clr_ptr=1, ready=0
  - all rdata=0, parity_err=0
  - Array contents are not touched by reset itself.
- State CLEAR, per edge with rst_n=1:
  - RF[clr_ptr] <= 0; clr_ptr <= clr_ptr+1.
  - On the edge that clears entry DEPTH-1: state <= READY, ready <= 1.
  - ready therefore rises on the (DEPTH-1)th edge after reset release (31 edges for DEPTH=32).
  - In CLEAR, external writes are ignored and every rdata port is loaded with 0.
- State READY:
  - Write: if we=1 and waddr!=0, RF[waddr] <= wdata at the edge. Writes to address 0 are discarded.
  - Read: each edge, for every port i, rdata_i <= value of RF[raddr_i]; 1-cycle latency.
  - raddr_i=0 always yields 0.
  - Bypass: if we=1, waddr!=0 and waddr==raddr_i in the same cycle, rdata_i <= wdata (new data, not old).
  - Multiple ports with the same address all receive identical data, including bypass.
- Reset mid-operation: a reset during CLEAR restarts the sequence from entry 1. A reset during READY drops ready and re-clears the whole array.
- State encoding: 1 bit (CLEAR=0, READY=1). No other states.
- No X propagation: entries are never read uninitialised after ready=1.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit, computed from wdata on write (0 for cleared entries).
  - On every non-bypassed read in READY of a nonzero address, stored parity is recomputed.
  - A mismatch sets parity_err=1 at the same edge rdata updates. It stays 1 until reset.
  - rdata still returns the stored (possibly corrupt) value.
- Undefined: no parity storage; parity_err is tied to 0.

Test Plan:
1. Clear sequence: DEPTH=32; hold rst_n=0 2 cycles, release; while ready=0, issue we=1 waddr=5 wdata=0xDEADBEEF.
   - Required: ready=1 exactly 31 edges after release.
   - Required: RF[5] reads 0x00000000; rdata=0 throughout CLEAR.
2. Basic write/read: write 0x12345678 to r7.
   - Required: next cycle raddr0=7 gives rdata0=0x12345678 one edge later.
   - Required: write 0xFFFFFFFF to r0, then raddr1=0 gives rdata1=0.
3. Bypass: r3 holds 0x11111111; same cycle we=1 waddr=3 wdata=0x22222222 with raddr0=3, raddr1=3.
   - Required: both rdata=0x22222222 after that edge.
   - Required: a read with waddr=4 wdata=0x33333333 and raddr0=3 returns 0x22222222.
4. Reset mid-clear: assert rst_n=0 for 1 cycle at clr_ptr=10, after having preloaded r20 via a prior READY phase.
   - Required: ready stays 0 for 31 further edges from release.
   - Required: r20 reads 0.
5. NUM_READ=4, WIDTH=16, DEPTH=16: write distinct values 0x0A01..0x0A0F to r1..r15; read r1, r2, r15, r0 on ports 0..3.
   - Required: 0x0A01, 0x0A02, 0x0A0F, 0x0000.
6. With RF_PARITY_EN: write 0x000000FF to r9, then backdoor-flip bit 0 of RF[9] and read r9.
   - Required: rdata=0x000000FE and parity_err=1 on that edge, held until rst_n=0.
   - Without the macro: parity_err stays 0.
